// File: rtl/ahb_cmd_pkg.sv
// Shared types for the AHB command queue: sequencer state and the buffered command record.
// Combinational only; no storage and no handshakes.
package ahb_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic        write;
      logic        burst;
      logic        sec;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/ahb_cmd_fifo.sv
// Synchronous FIFO with registered occupancy; head_dat shows the oldest entry with no read latency.
// The caller gates push with !full and pop with !empty; simultaneous push and pop leave count unchanged.
module ahb_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   assign head_dat = mem[rd_ptr];
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);

endmodule

// File: rtl/ahb_cmd_queue.sv
// Buffers requests and runs them one at a time on the cmd_start/cmd_done handshake; start two cycles after accept.
// req_ready drops when the FIFO is full; a response is held in RESP until rsp_ready, stalling further issue.
module ahb_cmd_queue
   import ahb_cmd_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                       hclk,
   input  logic                       hreset,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic                       req_burst,
   input  logic [31:0]                req_addr,
   input  logic [31:0]                req_wdata,
   input  logic                       req_sec,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [31:0]                rsp_rdata,
   output logic                       rsp_error,
   output logic                       rsp_timeout,
   output logic                       cmd_start,
   output logic                       cmd_write,
   output logic                       cmd_burst,
   output logic                       cmd_sec,
   output logic [31:0]                cmd_addr,
   output logic [31:0]                cmd_wdata,
   input  logic                       cmd_done,
   input  logic                       cmd_error,
   input  logic [31:0]                cmd_rdata,
   output logic [$clog2(DEPTH+1)-1:0] q_count,
   output logic                       busy
);

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t        state;
   state_t        state_nxt;
   cmd_t          req_cmd;
   cmd_t          head;
   cmd_t          cur;
   logic [TW-1:0] tmr;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          tmo_hit;

   assign req_cmd   = '{write: req_write, burst: req_burst, sec: req_sec,
                        addr: req_addr, wdata: req_wdata};
   assign req_ready = !fifo_full;
   assign push      = req_valid && req_ready;
   assign tmo_hit   = (TIMEOUT != 0) && (int'(tmr) + 1 >= TIMEOUT);
   // The head entry stays in the FIFO until its transfer finishes.
   assign pop       = (state == WAIT) && (cmd_done || tmo_hit);

   ahb_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk      (hclk),
      .rst      (hreset),
      .push     (push),
      .push_dat (req_cmd),
      .pop      (pop),
      .head_dat (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (q_count)
   );

   always_ff @(posedge hclk) begin
      if (hreset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fifo_empty) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (pop) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_start = (state == ISSUE);
      rsp_valid = (state == RESP);
      busy      = (state != IDLE) || !fifo_empty;
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         cur         <= '0;
         tmr         <= '0;
         rsp_rdata   <= '0;
         rsp_error   <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         if (state == IDLE && !fifo_empty) cur <= head;
         else if (pop)                     cur <= '0;

         if (state != WAIT)              tmr <= '0;
         else if (tmr != TW'(TIMEOUT))   tmr <= tmr + 1'b1;

         // A completion in the final timer cycle is reported as a normal completion.
         if (pop) begin
            rsp_error   <= cmd_done ? cmd_error : 1'b1;
            rsp_timeout <= !cmd_done;
            rsp_rdata   <= (cmd_done && !cur.write && !cmd_error) ? cmd_rdata : 32'h0;
         end else if (state == RESP && rsp_ready) begin
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= 32'h0;
         end
      end
   end

   assign cmd_write = cur.write;
   assign cmd_burst = cur.burst;
   assign cmd_sec   = cur.sec;
   assign cmd_addr  = cur.addr;
   assign cmd_wdata = cur.wdata;

endmodule
